// File: rtl/execute_stage_pkg.sv
// definitions: shared widths and enums for the SIWO execute stage.
// The state literals carry an EX_ prefix because MUL is already an
// aluOp_t literal in this package.
package definitions;

  localparam int DATA_WIDTH = 16;
  localparam int REG_WIDTH  = 4;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SLL = 3'd5,
    SRL = 3'd6,
    MUL = 3'd7
  } aluOp_t;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_MUL  = 2'd1,
    EX_DONE = 2'd2
  } execState_t;

endpackage

// File: rtl/execute_stage_mul.sv
// seqMultiplier: unsigned shift-add multiplier, one partial product per cycle.
// start loads the operands; DW iterations follow. done is high during the
// cycle whose closing edge performs the final iteration, so product is
// complete from the next cycle on and holds until the next start.
module seqMultiplier #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int CW = $clog2(DW + 1);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  logic [2*DW-1:0] mcand;
  logic [DW-1:0]   mplier;
  logic [CW-1:0]   count;

  // final iteration happens at the end of this cycle
  assign done = busy && (count == LAST);

  // load operands on start, then accumulate one shifted partial product per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      count   <= '0;
      mcand   <= '0;
      mplier  <= '0;
      product <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      count   <= '0;
      mcand   <= {{DW{1'b0}}, a};
      mplier  <= b;
      product <= '0;
    end else if (busy) begin
      if (mplier[0]) begin
        product <= product + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 1'b1;
      if (count == LAST) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_stage.sv
// execute_stage: SIWO execute stage feeding the register file write port.
// Handshake: an operation transfers on a rising edge where _valid && ready;
// upstream holds its operation stable until that edge, and _valid while
// ready is low has no effect.
// Optional feature macro: SIWO_MUL_EN compiles in the iterative multiplier
// and the EX_MUL/EX_DONE states; without it MUL is a silent 1-cycle no-op.
module execute_stage
  import definitions::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int RW = REG_WIDTH
) (
  input  logic          _CLK,
  input  logic          _RST,
  input  logic          _valid,
  output logic          ready,
  input  aluOp_t        _op,
  input  logic          _writeEn,
  input  logic [RW-1:0] _regDest,
  input  logic [DW-1:0] _valueA,
  input  logic [DW-1:0] _valueB,
  output logic          regWrite,
  output logic [RW-1:0] regDest,
  output logic [DW-1:0] writeVal,
  output logic          zero,
  output logic          carry
);

  localparam int SW = $clog2(DW);

  logic          accept;
  logic [DW:0]   sumExt;
  logic [DW:0]   diffExt;
  logic [DW-1:0] aluRes;
  logic          aluCarry;

  assign accept  = _valid && ready;
  assign sumExt  = {1'b0, _valueA} + {1'b0, _valueB};
  // top bit of the widened difference is the unsigned borrow
  assign diffExt = {1'b0, _valueA} - {1'b0, _valueB};

  // single-cycle ALU on the operands presented this cycle
  always_comb begin
    aluRes   = '0;
    aluCarry = 1'b0;
    case (_op)
      ADD: begin aluRes = sumExt[DW-1:0];  aluCarry = sumExt[DW];  end
      SUB: begin aluRes = diffExt[DW-1:0]; aluCarry = diffExt[DW]; end
      AND: aluRes = _valueA & _valueB;
      OR:  aluRes = _valueA | _valueB;
      XOR: aluRes = _valueA ^ _valueB;
      SLL: aluRes = _valueA << _valueB[SW-1:0];
      SRL: aluRes = _valueA >> _valueB[SW-1:0];
      default: begin aluRes = '0; aluCarry = 1'b0; end
    endcase
  end

`ifdef SIWO_MUL_EN

  execState_t      state;
  logic            pendWe;
  logic [RW-1:0]   pendDest;
  logic            mulStart;
  logic            mulBusy;
  logic            mulDone;
  logic [2*DW-1:0] mulProduct;

  assign ready    = (state == EX_IDLE);
  assign mulStart = accept && (_op == MUL);

  seqMultiplier #(.DW(DW)) uMul (
    .clk     (_CLK),
    .rst     (_RST),
    .start   (mulStart),
    .a       (_valueA),
    .b       (_valueB),
    .busy    (mulBusy),
    .done    (mulDone),
    .product (mulProduct)
  );

  // issue FSM: single-cycle ops complete at accept, MUL parks in EX_MUL/EX_DONE
  always_ff @(posedge _CLK) begin
    if (_RST) begin
      state    <= EX_IDLE;
      regWrite <= 1'b0;
      regDest  <= '0;
      writeVal <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      pendWe   <= 1'b0;
      pendDest <= '0;
    end else begin
      regWrite <= 1'b0;
      case (state)
        EX_IDLE: begin
          if (accept) begin
            if (_op == MUL) begin
              state    <= EX_MUL;
              pendWe   <= _writeEn;
              pendDest <= _regDest;
            end else begin
              writeVal <= aluRes;
              regDest  <= _regDest;
              regWrite <= _writeEn;
              zero     <= (aluRes == '0);
              carry    <= aluCarry;
            end
          end
        end
        EX_MUL: begin
          // a multiplier that stopped without finishing would strand the stage
          if (mulDone) begin
            state <= EX_DONE;
          end else if (!mulBusy) begin
            state <= EX_IDLE;
          end
        end
        EX_DONE: begin
          writeVal <= mulProduct[DW-1:0];
          regDest  <= pendDest;
          regWrite <= pendWe;
          zero     <= (mulProduct[DW-1:0] == '0);
          carry    <= |mulProduct[2*DW-1:DW];
          state    <= EX_IDLE;
        end
        default: state <= EX_IDLE;
      endcase
    end
  end

`else

  assign ready = 1'b1;

  // every op completes in its accept cycle; MUL leaves outputs and flags alone
  always_ff @(posedge _CLK) begin
    if (_RST) begin
      regWrite <= 1'b0;
      regDest  <= '0;
      writeVal <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
    end else begin
      regWrite <= 1'b0;
      if (accept && (_op != MUL)) begin
        writeVal <= aluRes;
        regDest  <= _regDest;
        regWrite <= _writeEn;
        zero     <= (aluRes == '0);
        carry    <= aluCarry;
      end
    end
  end

`endif

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed and random checks of execute_stage, with a
// scoreboard of expected register-file writes {dest, value, zero, carry}.
module tb_execute_stage;
  import definitions::*;

  localparam int DW = DATA_WIDTH;
  localparam int RW = REG_WIDTH;
  localparam int EW = RW + DW + 2;

  logic          clk;
  logic          rst;
  logic          valid;
  logic          ready;
  aluOp_t        op;
  logic          writeEn;
  logic [RW-1:0] dest;
  logic [DW-1:0] valA;
  logic [DW-1:0] valB;
  logic          regWrite;
  logic [RW-1:0] regDest;
  logic [DW-1:0] writeVal;
  logic          zero;
  logic          carry;

  int tests = 0;
  int fails = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  logic [EW-1:0] got_e;

  execute_stage dut (
    ._CLK     (clk),
    ._RST     (rst),
    ._valid   (valid),
    .ready    (ready),
    ._op      (op),
    ._writeEn (writeEn),
    ._regDest (dest),
    ._valueA  (valA),
    ._valueB  (valB),
    .regWrite (regWrite),
    .regDest  (regDest),
    .writeVal (writeVal),
    .zero     (zero),
    .carry    (carry)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: tb did not finish");
    $fatal(1, "watchdog");
  end

  // reference model: {carry, result}
  function automatic logic [DW:0] model(input aluOp_t o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [2*DW-1:0] w;
    logic [DW-1:0]   r;
    logic            c;
    int              sh;
    w  = '0;
    r  = '0;
    c  = 1'b0;
    sh = int'(b) % DW;
    case (o)
      ADD: begin w = {{DW{1'b0}}, a} + {{DW{1'b0}}, b}; r = w[DW-1:0]; c = w[DW]; end
      SUB: begin r = a - b; c = (a < b); end
      AND: r = a & b;
      OR:  r = a | b;
      XOR: r = a ^ b;
      SLL: r = a << sh;
      SRL: r = a >> sh;
      MUL: begin w = {{DW{1'b0}}, a} * {{DW{1'b0}}, b}; r = w[DW-1:0]; c = (w[2*DW-1:DW] != '0); end
      default: r = '0;
    endcase
    return {c, r};
  endfunction

  function automatic logic [EW-1:0] entry(input aluOp_t o, input logic [RW-1:0] d,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] m;
    m = model(o, a, b);
    return {d, m[DW-1:0], (m[DW-1:0] == '0), m[DW]};
  endfunction

  // scoreboard: every write pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && regWrite === 1'b1) begin
      got_e = {regDest, writeVal, zero, carry};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write got dest=%0d val=%h z=%b c=%b, required no write",
                 regDest, writeVal, zero, carry);
      end else begin
        exp_e = exp_q.pop_front();
        if (got_e !== exp_e) begin
          fails++;
          $display("FAIL write_data got dest=%0d val=%h z=%b c=%b, required dest=%0d val=%h z=%b c=%b",
                   got_e[EW-1 -: RW], got_e[DW+1:2], got_e[1], got_e[0],
                   exp_e[EW-1 -: RW], exp_e[DW+1:2], exp_e[1], exp_e[0]);
        end
      end
    end
  end

  // driver: present an op at a negedge, hold until accepted, return at the next negedge
  task automatic issue(input aluOp_t o, input logic we, input logic [RW-1:0] d,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, input bit expectWrite);
    int waitc;
    waitc   = 0;
    valid   = 1'b1;
    op      = o;
    writeEn = we;
    dest    = d;
    valA    = a;
    valB    = b;
    while (ready !== 1'b1 && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 200) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout got ready=%b, required ready=1 within 200 cycles", ready);
    end
    @(posedge clk);
    if (expectWrite && we) exp_q.push_back(entry(o, d, a, b));
    @(negedge clk);
  endtask

  task automatic idle();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++; if (ready !== 1'b1)    begin fails++; $display("FAIL reset_ready got %b required 1", ready); end
    tests++; if (regWrite !== 1'b0) begin fails++; $display("FAIL reset_regWrite got %b required 0", regWrite); end
    tests++; if (writeVal !== '0)   begin fails++; $display("FAIL reset_writeVal got %h required 0", writeVal); end
    tests++; if (regDest !== '0)    begin fails++; $display("FAIL reset_regDest got %0d required 0", regDest); end
    tests++; if (zero !== 1'b0)     begin fails++; $display("FAIL reset_zero got %b required 0", zero); end
    tests++; if (carry !== 1'b0)    begin fails++; $display("FAIL reset_carry got %b required 0", carry); end
  endtask

  task automatic test_add_sub();
    issue(ADD, 1'b1, 4'd2, 16'd10, 16'd7, 1'b1);
    tests++; if (regWrite !== 1'b1) begin fails++; $display("FAIL add_latency got regWrite=%b required 1", regWrite); end
    tests++; if (writeVal !== 16'd17) begin fails++; $display("FAIL add_value got %0d required 17", writeVal); end
    issue(SUB, 1'b1, 4'd3, 16'd5, 16'd5, 1'b1);
    idle();
    tests++; if (regWrite !== 1'b1 || zero !== 1'b1) begin
      fails++; $display("FAIL sub_back_to_back got regWrite=%b zero=%b required 1 1", regWrite, zero);
    end
    @(negedge clk);
    tests++; if (regWrite !== 1'b0) begin fails++; $display("FAIL pulse_width got regWrite=%b required 0", regWrite); end
  endtask

  task automatic test_write_disable();
    issue(SUB, 1'b0, 4'd9, 16'd3, 16'd4, 1'b1);
    idle();
    tests++; if (regWrite !== 1'b0) begin fails++; $display("FAIL we0_regWrite got %b required 0", regWrite); end
    tests++; if (writeVal !== 16'hFFFF) begin fails++; $display("FAIL we0_writeVal got %h required ffff", writeVal); end
    tests++; if (carry !== 1'b1 || zero !== 1'b0) begin
      fails++; $display("FAIL we0_flags got c=%b z=%b required c=1 z=0", carry, zero);
    end
  endtask

  task automatic test_shift_wrap();
    issue(SLL, 1'b1, 4'd5, 16'd1, 16'(DW + 1), 1'b1);
    idle();
    tests++; if (writeVal !== 16'd2) begin fails++; $display("FAIL sll_wrap got %0d required 2", writeVal); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) begin
      issue(aluOp_t'($urandom_range(0, 6)), 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b1);
    end
    idle();
    @(negedge clk);
  endtask

`ifdef SIWO_MUL_EN
  task automatic test_mul();
    int lowCycles;
    lowCycles = 0;
    issue(MUL, 1'b1, 4'd4, 16'd11, 16'd5, 1'b1);
    // offer an ADD while the multiplier is busy; it must wait
    valid = 1'b1; op = ADD; writeEn = 1'b1; dest = 4'd5; valA = 16'd100; valB = 16'd23;
    while (ready === 1'b0 && lowCycles < DW + 10) begin
      lowCycles++;
      @(negedge clk);
    end
    tests++; if (lowCycles != DW + 1) begin fails++; $display("FAIL mul_busy_cycles got %0d required %0d", lowCycles, DW + 1); end
    tests++; if (regWrite !== 1'b1 || writeVal !== 16'd55) begin
      fails++; $display("FAIL mul_result got regWrite=%b val=%0d required 1 55", regWrite, writeVal);
    end
    @(posedge clk);
    exp_q.push_back(entry(ADD, 4'd5, 16'd100, 16'd23));
    @(negedge clk);
    idle();
    tests++; if (writeVal !== 16'd123) begin fails++; $display("FAIL add_after_mul got %0d required 123", writeVal); end
    issue(MUL, 1'b1, 4'd6, 16'h1234, 16'h0100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      issue(MUL, 1'b1, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b1);
    end
    issue(MUL, 1'b0, 4'd1, 16'd0, 16'd77, 1'b1);
    idle();
    repeat (DW + 4) @(negedge clk);
    tests++; if (zero !== 1'b1 || carry !== 1'b0) begin
      fails++; $display("FAIL mul_we0_flags got z=%b c=%b required z=1 c=0", zero, carry);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit sawPulse;
    sawPulse = 1'b0;
    issue(MUL, 1'b1, 4'd6, 16'd300, 16'd200, 1'b0);
    idle();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (ready !== 1'b1 || regWrite !== 1'b0 || writeVal !== '0) begin
      fails++; $display("FAIL mid_mul_reset got ready=%b regWrite=%b val=%h required 1 0 0", ready, regWrite, writeVal);
    end
    for (int i = 0; i < DW + 4; i++) begin
      if (regWrite === 1'b1) sawPulse = 1'b1;
      @(negedge clk);
    end
    tests++; if (sawPulse) begin fails++; $display("FAIL aborted_mul_write got a pulse required none"); end
    issue(ADD, 1'b1, 4'd7, 16'd1, 16'd2, 1'b1);
    idle();
    tests++; if (writeVal !== 16'd3) begin fails++; $display("FAIL add_after_reset got %0d required 3", writeVal); end
  endtask
`else
  task automatic test_mul_noop();
    logic prevZero;
    logic prevCarry;
    bit   dropped;
    prevZero  = zero;
    prevCarry = carry;
    dropped   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(MUL, 1'b1, 4'd8, 16'd11, 16'd5, 1'b0);
      if (ready !== 1'b1) dropped = 1'b1;
    end
    idle();
    tests++; if (regWrite !== 1'b0) begin fails++; $display("FAIL mul_noop_write got %b required 0", regWrite); end
    tests++; if (zero !== prevZero || carry !== prevCarry) begin
      fails++; $display("FAIL mul_noop_flags got z=%b c=%b required z=%b c=%b", zero, carry, prevZero, prevCarry);
    end
    tests++; if (dropped) begin fails++; $display("FAIL mul_noop_ready got a low ready required always 1"); end
  endtask
`endif

  initial begin
    rst = 1'b1; valid = 1'b0; op = ADD; writeEn = 1'b0; dest = '0; valA = '0; valB = '0;
    test_reset();
    test_add_sub();
    test_write_disable();
    test_shift_wrap();
    test_back_to_back();
`ifdef SIWO_MUL_EN
    test_mul();
    test_reset_mid_mul();
`else
    test_mul_noop();
`endif
    repeat (4) @(negedge clk);
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL missing_writes got %0d pending required 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
